// File: rtl/pipe_pkg.sv
// Shared widths and payload bundles for the pipelined core's inter-stage registers.
// Stages pack and unpack through these structs so field order stays consistent.
package pipe_pkg;

  // ID/EX
  localparam int DE_DATA_W = 175;
  localparam int DE_CTRL_W = 10;
  // EX/MEM
  localparam int EM_DATA_W = 101;
  localparam int EM_CTRL_W = 4;
  // MEM/WB
  localparam int MW_DATA_W = 101;
  localparam int MW_CTRL_W = 3;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_ext;
    logic [31:0] pc_plus4;
  } de_data_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
  } de_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } em_data_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
  } em_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } mw_data_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } mw_ctrl_t;

  // EX/MEM bit offsets (LSB of each field) within the flat payload
  localparam int EM_PC4_LSB = 0;
  localparam int EM_RD_LSB  = 32;
  localparam int EM_WD_LSB  = 37;
  localparam int EM_ALU_LSB = 69;

endpackage

// File: rtl/pipe_skid_slot.sv
// Overflow slot for the elastic stage: one beat of payload + control with a valid flag.
// Clear beats load so a flush always empties the slot.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = EM_DATA_W,
  parameter int CTRL_W = EM_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with flush and optional skid slot.
// Control bits read zero whenever no valid beat is held.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = EM_DATA_W,
  parameter int CTRL_W = EM_CTRL_W,
  parameter int SKID   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic              r_alive;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic [CTRL_W-1:0] w_skid_ctrl;

  // r_alive holds in_ready low until the first edge after reset releases
  generate
    if (SKID != 0) begin : g_skid
      logic w_skid_load;
      logic w_skid_clear;

      assign w_skid_load  = w_in_fire & r_valid & ~out_ready & ~flush;
      assign w_skid_clear = flush | (w_skid_valid & w_out_fire);
      assign in_ready     = r_alive & ~w_skid_valid;

      pipe_skid_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_ctrl  (w_skid_ctrl)
      );
    end else begin : g_noskid
      assign w_skid_valid = 1'b0;
      assign w_skid_data  = '0;
      assign w_skid_ctrl  = '0;
      assign in_ready     = r_alive & (out_ready | ~r_valid);
    end
  endgenerate

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alive <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else begin
      r_alive <= 1'b1;
      if (flush) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end else if (w_skid_valid && w_out_fire) begin
        r_valid <= 1'b1;
        r_data  <= w_skid_data;
        r_ctrl  <= w_skid_ctrl;
      end else if (w_in_fire && (!r_valid || w_out_fire)) begin
        r_valid <= 1'b1;
        r_data  <= in_data;
        r_ctrl  <= in_ctrl;
      end else if (w_out_fire) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ctrl  = r_ctrl;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=0 and a SKID=1 instance from shared stimulus; each has its own
// queue-based occupancy model and scoreboard checked on the falling edge.
module tb_pipe_stage_reg;
  localparam int DW = 101;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic flush = 1'b0;
  logic out_ready = 1'b0;

  logic [1:0]         w_in_ready;
  logic [1:0]         w_out_valid;
  logic [1:0][DW-1:0] w_out_data;
  logic [1:0][CW-1:0] w_out_ctrl;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int inst, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL skid%0d %s t=%0t got=%0h exp=%0h", inst, nm, $time, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(g)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (w_in_ready[g]),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .flush     (flush),
      .out_valid (w_out_valid[g]),
      .out_ready (out_ready),
      .out_data  (w_out_data[g]),
      .out_ctrl  (w_out_ctrl[g])
    );

    // Expected beats in arrival order; the front is what the stage must present.
    logic [DW+CW-1:0] q[$];
    logic alive = 1'b0;

    always @(negedge clk) begin
      logic exp_v, exp_rdy;
      logic [DW+CW-1:0] front;
      if (reset) begin
        q.delete();
        alive = 1'b0;
        chk("rst_in_ready", g, {127'b0, w_in_ready[g]}, 128'd0);
        chk("rst_out_valid", g, {127'b0, w_out_valid[g]}, 128'd0);
        chk("rst_out_ctrl", g, {124'b0, w_out_ctrl[g]}, 128'd0);
        chk("rst_out_data", g, {27'b0, w_out_data[g]}, 128'd0);
      end else begin
        exp_v   = (q.size() > 0);
        exp_rdy = alive && ((g == 1) ? (q.size() < 2) : (out_ready || q.size() == 0));
        chk("in_ready", g, {127'b0, w_in_ready[g]}, {127'b0, exp_rdy});
        chk("out_valid", g, {127'b0, w_out_valid[g]}, {127'b0, exp_v});
        if (exp_v) begin
          front = q[0];
          chk("out_ctrl", g, {124'b0, w_out_ctrl[g]}, {124'b0, front[CW-1:0]});
          chk("out_data", g, {27'b0, w_out_data[g]}, {27'b0, front[DW+CW-1:CW]});
        end else begin
          chk("idle_ctrl", g, {124'b0, w_out_ctrl[g]}, 128'd0);
        end
        // effect of the coming rising edge
        if (flush) q.delete();
        else begin
          if (exp_v && out_ready) void'(q.pop_front());
          if (in_valid && exp_rdy) q.push_back({in_data, in_ctrl});
        end
        alive = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    in_data = r[DW-1:0];
    in_ctrl = r[CW-1:0] ^ r[100:97];
  endtask

  initial begin
    // first beat comes straight out of reset
    in_valid = 1'b1;
    in_data = {{(DW-32){1'b0}}, 32'hDEADBEEF};
    in_ctrl = 4'b1001;
    out_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();
    in_valid = 1'b0;
    repeat (2) step();

    // downstream stall with input held
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b0;
      in_data = DW'(100 + i);
      in_ctrl = CW'(i + 2);
      step();
    end
    out_ready = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    repeat (3) step();

    // fill main and skid, then flush with a beat offered
    in_valid = 1'b1;
    in_ctrl = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = DW'(200 + i);
      step();
    end
    flush = 1'b1;
    in_data = DW'(299);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();

    // ordered stream with out_ready pattern 1,0,0,1
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data = DW'(i);
      in_ctrl = CW'(i);
      out_ready = ((i % 4) == 1) || ((i % 4) == 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    // async reset pulse between edges while beats are held
    in_valid = 1'b1;
    in_ctrl = 4'b0110;
    out_ready = 1'b0;
    repeat (3) step();
    #1;
    reset = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("async_valid", g, {127'b0, w_out_valid[g]}, 128'd0);
      chk("async_ctrl", g, {124'b0, w_out_ctrl[g]}, 128'd0);
    end
    step();
    step();
    reset = 1'b0;
    step();

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      in_valid = ($urandom_range(99) < 75);
      out_ready = ($urandom_range(99) < 70);
      flush = ($urandom_range(99) < 3);
      rnd_data();
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int g = 0; g < 2; g++)
        assert (w_out_valid[g] || w_out_ctrl[g] == '0)
          else $error("out_ctrl nonzero with out_valid low on instance %0d", g);
    end
  end

endmodule
